// File: rtl/median7_frame_ctrl.sv
// ---------------------------------------------------------------------------
// median7_frame_ctrl
//
// Collects 4-bit samples into non-overlapping frames of seven, computes the
// median (4th smallest, unsigned) of each frame with a 7-input combinational
// median finder, and returns one registered median per frame.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. A valid seen with ready low consumes nothing.
// Ready and valid outputs are pure decodes of the state register.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream sample valid
//   in_data    4-bit unsigned sample
//   in_ready   block accepts a sample this cycle (COLLECT only)
//   out_valid  median register holds an undelivered result (OUT only)
//   out_ready  downstream accepts the median this cycle
//   median     median of the last completed frame
//   frame_cnt  medians delivered since reset, wraps silently
// ---------------------------------------------------------------------------
module median7_frame_ctrl #(
   parameter int FRAME_CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [3:0]             in_data,
   output logic                   in_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [3:0]             median,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      CALC    = 2'd1,
      OUT     = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [2:0] cnt;
   logic [3:0] slots [7];
   logic [3:0] med_c;
   logic [2:0] rank [7];
   logic       in_fire;
   logic       out_fire;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= COLLECT;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (in_fire && cnt == 3'd6) state_nxt = CALC;
         CALC:    state_nxt = OUT;
         OUT:     if (out_fire) state_nxt = COLLECT;
         default: state_nxt = COLLECT;
      endcase
   end

   // ---------------- FSM: output decode ----------------
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         COLLECT: in_ready  = 1'b1;
         OUT:     out_valid = 1'b1;
         default: ;
      endcase
   end

   // ---------------- Datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= 3'd0;
         median    <= 4'd0;
         frame_cnt <= '0;
         for (int i = 0; i < 7; i++) slots[i] <= 4'd0;
      end else begin
         if (in_fire) begin
            slots[cnt] <= in_data;
            cnt        <= (cnt == 3'd6) ? 3'd0 : cnt + 3'd1;
         end
         if (state == CALC) median <= med_c;
         if (out_fire) frame_cnt <= frame_cnt + 1'b1;
      end
   end

   // ---------------- 7-input median finder ----------------
   // Each slot gets a unique rank: the number of slots strictly smaller,
   // plus equal slots with a lower index. Equal values are thereby ordered
   // by position, so the ranks form a permutation of 0..6 and exactly one
   // slot has rank 3 -- that slot is the median.
   always_comb begin
      med_c = 4'd0;
      for (int i = 0; i < 7; i++) begin
         rank[i] = 3'd0;
         for (int j = 0; j < 7; j++) begin
            if (j != i && ((slots[j] < slots[i]) ||
                           (slots[j] == slots[i] && j < i))) begin
               rank[i] = rank[i] + 3'd1;
            end
         end
         if (rank[i] == 3'd3) med_c = slots[i];
      end
   end

endmodule

// File: doc/median7_frame_ctrl.md
# median7_frame_ctrl

Sequential wrapper around the 7-input combinational median finder. It accepts a stream of 4-bit samples over a valid/ready handshake and groups them into non-overlapping frames of 7. It computes the median of each frame through an internal 7-input median finder and returns one registered median per frame over a second valid/ready handshake. It sits directly upstream and downstream of the combinational median finder: it feeds it and consumes its result.

## Interface
- FRAME_CNT_W, default 8: width of the delivered-frame counter.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream sample valid.
- in_data  input  4  unsigned sample.
- in_ready  output  1  block can accept a sample this cycle.
- out_valid  output  1  median holding register is valid.
- out_ready  input  1  downstream accepts median this cycle.
- median  output  4  median (4th smallest, unsigned) of the last completed frame.
- frame_cnt  output  FRAME_CNT_W  number of medians delivered since reset.

## Operation
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - state = COLLECT, slot count = 0, slots[0..6] = 0.
  - median = 0, out_valid = 0, frame_cnt = 0.
  - in_ready = 1 once rst_n is high.
- A transfer happens on a rising edge where valid and ready are both 1. A valid with ready low is ignored and consumes nothing.
- State COLLECT:
  - in_ready = 1, out_valid = 0.
  - On each input transfer, in_data is written to slots[count] and count increments.
  - The transfer with count = 6 writes slots[6], resets count to 0, and moves to CALC.
- State CALC, exactly one cycle:
  - in_ready = 0, out_valid = 0.
  - slots[0..6] drive the combinational median finder in slot order.
  - At the end of the cycle, median is loaded from the finder and the state moves to OUT.
- State OUT:
  - in_ready = 0, out_valid = 1, median held stable.
  - On an output transfer (out_ready = 1): frame_cnt increments, state returns to COLLECT, out_valid falls the next cycle.
  - out_valid stays high and median stays constant for as long as out_ready is low. There is no timeout.
- Median rule: unsigned compare. Ties count as separate entries, so the result is always one of the 7 frame samples.
- frame_cnt wraps from 2^FRAME_CNT_W − 1 to 0 with no flag.
- in_ready is a pure decode of state and does not depend on in_valid or out_ready. No combinational path from inputs to outputs.
- Slots are not cleared between frames. Every slot is overwritten before each CALC.
- Reset asserted mid-frame or mid-OUT: all registers take their reset values immediately. A partial frame is discarded and a pending median is dropped without being counted.

## Timing
- The 7th input transfer happens at edge E:
  - CALC is the cycle after E.
  - median and out_valid = 1 are visible after edge E+1.
- Minimum frame period is 9 cycles: 7 COLLECT + 1 CALC + 1 OUT with out_ready held high.
- The first sample of the next frame can transfer at the edge after the output transfer, not in the same cycle.
- Gaps in in_valid stretch COLLECT. Samples keep strict arrival order and none is dropped or duplicated.
- The critical path is slot registers → median finder → median register. It is a single-cycle path with no multicycle constraint.

## Test plan
- Reset, then frame 3,7,1,9,4,6,2 with in_valid held high and out_ready = 1:
  - in_ready = 0 for exactly 2 cycles after the 7th transfer.
  - median = 4 with out_valid high for 1 cycle.
  - frame_cnt = 1.
- Frame 5,5,5,0,15,15,0 → median = 5. Frame 15×7 → median = 15. Frame 0×7 → median = 0.
- Backpressure: frame 8,1,2,3,4,5,6 with out_ready low for 10 cycles:
  - median = 4 and out_valid stay stable the whole time, and in_ready stays 0.
  - Raising out_ready gives one transfer, and frame_cnt increments by 1.
- Sparse input: randomly gate in_valid across 20 frames, compare against a sort-based model, and expect 20 correct medians in order.
- Reset mid-operation:
  - Assert rst_n low after 4 samples: all outputs return to reset values, and the next 7 samples form a fresh frame.
  - Repeat with rst_n low during OUT: the pending median is discarded and frame_cnt = 0.
- Wrap: with FRAME_CNT_W = 2, deliver 5 frames → frame_cnt goes 1,2,3,0,1.
